// File: rtl/odesa_pkg.sv
// -----------------------------------------------------------------------------
// odesa_pkg
// Shared types and helpers for the ODESA integrate-and-fire neuron.
//   state_t   : neuron FSM states (idle / firing / refractory)
//   calc_sw   : width of a trace sum, TW + clog2(P_N), so the sum cannot overflow
//   sat_add   : add that clamps at an upper bound (threshold ceiling)
//   floor_sub : subtract that clamps at a lower bound (threshold floor)
// -----------------------------------------------------------------------------
package odesa_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FIRE    = 2'd1,
        S_REFRACT = 2'd2
    } state_t;

    function automatic int calc_sw(input int n, input int tw);
        return tw + $clog2(n);
    endfunction

    // The 33-bit intermediate keeps the carry so the clamp cannot be fooled by wrap-around
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_val}) ? max_val : s[31:0];
    endfunction

    function automatic logic [31:0] floor_sub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] floor_val);
        if ((a < b) || ((a - b) < floor_val)) begin
            return floor_val;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/odesa_neuron_trace_adder.sv
// -----------------------------------------------------------------------------
// trace_adder
// Registered unsigned sum of P_N synapse traces.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_trace        : P_N concatenated traces, synapse k at [k*TW +: TW]
//   o_sum          : registered sum, SW bits wide (never overflows)
// -----------------------------------------------------------------------------
module trace_adder
    import odesa_pkg::*;
#(
    parameter int P_N  = 4,
    parameter int TW   = 16,
    localparam int SW  = calc_sw(P_N, TW)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [P_N*TW-1:0] i_trace,
    output logic [SW-1:0]     o_sum
);

    logic [SW-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < P_N; k++) begin
            sum_c = sum_c + SW'(i_trace[k*TW +: TW]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum <= '0;
        end else begin
            o_sum <= sum_c;
        end
    end

endmodule

// File: rtl/odesa_neuron.sv
// -----------------------------------------------------------------------------
// odesa_neuron
// Integrate-and-fire neuron with adaptive (homeostatic) threshold.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_trace        : P_N concatenated synapse traces (TW bits each)
//   i_th_load      : load i_th_value (clamped to the floor) into the threshold
//   i_th_value     : threshold load value
//   o_spike        : one-cycle spike pulse
//   o_refract      : high while firing or refractory
//   o_sum          : registered trace sum
//   o_thresh       : current threshold
// The threshold rises by P_TH_INC on every spike (saturating) and relaxes by one
// LSB every P_TH_DECAY idle cycles, never below P_TH_MIN.
// -----------------------------------------------------------------------------
module odesa_neuron
    import odesa_pkg::*;
#(
    parameter int P_N        = 4,
    parameter int P_WIDTH    = 8,
    parameter int P_NBIT     = 8,
    parameter int P_REFRACT  = 4,
    parameter int P_TH_INIT  = 32768,
    parameter int P_TH_MIN   = 1024,
    parameter int P_TH_INC   = 2048,
    parameter int P_TH_DECAY = 64,
    localparam int TW        = P_WIDTH + P_NBIT,
    localparam int SW        = calc_sw(P_N, TW)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [P_N*TW-1:0] i_trace,
    input  logic              i_th_load,
    input  logic [SW-1:0]     i_th_value,
    output logic              o_spike,
    output logic              o_refract,
    output logic [SW-1:0]     o_sum,
    output logic [SW-1:0]     o_thresh
);

    localparam int          RW       = $clog2(P_REFRACT + 1);
    localparam int          DW       = $clog2(P_TH_DECAY + 1);
    localparam logic [31:0] TH_MAX32 = (32'd1 << SW) - 32'd1;
    localparam logic [SW-1:0] TH_MIN = SW'(P_TH_MIN);

    state_t         state;
    state_t         next_state;
    logic [RW-1:0]  refr_cnt;
    logic [DW-1:0]  decay_cnt;
    logic           fire_now;

    trace_adder #(
        .P_N (P_N),
        .TW  (TW)
    ) u_adder (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_trace (i_trace),
        .o_sum   (o_sum)
    );

    // Crossing test against the threshold as it stands this cycle; a load issued
    // in the same cycle only affects later comparisons.
    assign fire_now = (state == S_IDLE) && (o_sum >= o_thresh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (fire_now) next_state = S_FIRE;
            S_FIRE:    next_state = S_REFRACT;
            S_REFRACT: if (refr_cnt == '0) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Loaded on the way out of S_FIRE so that P_REFRACT=1 yields a single
    // refractory cycle (counter already zero on entry).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            refr_cnt <= '0;
        end else if (state == S_FIRE) begin
            refr_cnt <= RW'(P_REFRACT - 1);
        end else if ((state == S_REFRACT) && (refr_cnt != '0)) begin
            refr_cnt <= refr_cnt - 1'b1;
        end
    end

    // Outputs decoded from the next state and registered, so o_spike and
    // o_refract line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_spike   <= 1'b0;
            o_refract <= 1'b0;
        end else begin
            o_spike   <= (next_state == S_FIRE);
            o_refract <= (next_state != S_IDLE);
        end
    end

    // Threshold homeostasis: load beats spike increment beats idle decay.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_thresh  <= SW'(P_TH_INIT);
            decay_cnt <= '0;
        end else if (i_th_load) begin
            o_thresh  <= (i_th_value < TH_MIN) ? TH_MIN : i_th_value;
            decay_cnt <= '0;
        end else if (fire_now) begin
            o_thresh  <= SW'(sat_add(32'(o_thresh), 32'(P_TH_INC), TH_MAX32));
            decay_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (decay_cnt == DW'(P_TH_DECAY - 1)) begin
                decay_cnt <= '0;
                o_thresh  <= SW'(floor_sub(32'(o_thresh), 32'd1, 32'(P_TH_MIN)));
            end else begin
                decay_cnt <= decay_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_odesa_neuron.sv
// -----------------------------------------------------------------------------
// tb_odesa_neuron
// Self-checking bench for odesa_neuron. A cycle-level behavioural model
// (integer sum, threshold, remaining busy window, idle counter) predicts every
// output after each clock edge; directed steps cover reset, crossing, equality,
// saturation/floor, load priority and reset during refractory, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_odesa_neuron;

    localparam int P_N        = 4;
    localparam int TW         = 16;
    localparam int SW         = 18;
    localparam int P_REFRACT  = 4;
    localparam int P_TH_INIT  = 32768;
    localparam int P_TH_MIN   = 1024;
    localparam int P_TH_INC   = 2048;
    localparam int P_TH_DECAY = 64;
    localparam int TH_MAX     = (1 << SW) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [P_N*TW-1:0] i_trace;
    logic              i_th_load;
    logic [SW-1:0]     i_th_value;
    logic              o_spike;
    logic              o_refract;
    logic [SW-1:0]     o_sum;
    logic [SW-1:0]     o_thresh;

    int testCount = 0;
    int failCount = 0;

    int mSum, mTh, mBusy, mDecay;
    bit mSpike, mRefract;

    odesa_neuron dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_trace    (i_trace),
        .i_th_load  (i_th_load),
        .i_th_value (i_th_value),
        .o_spike    (o_spike),
        .o_refract  (o_refract),
        .o_sum      (o_sum),
        .o_thresh   (o_thresh)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".sum"},     32'(o_sum),     32'(mSum));
        checkOutput({tag, ".thresh"},  32'(o_thresh),  32'(mTh));
        checkOutput({tag, ".spike"},   32'(o_spike),   32'(mSpike));
        checkOutput({tag, ".refract"}, 32'(o_refract), 32'(mRefract));
    endtask

    task automatic modelReset();
        mSum = 0; mTh = P_TH_INIT; mBusy = 0; mDecay = 0;
        mSpike = 0; mRefract = 0;
    endtask

    task automatic setTraces(input int t0, input int t1, input int t2, input int t3);
        i_trace = {16'(t3), 16'(t2), 16'(t1), 16'(t0)};
    endtask

    // One clock: sample inputs, advance the model across the edge, compare 1ns later.
    task automatic applyStimulus(input string tag);
        int  inSum;
        bit  ld, rstOk, fire;
        int  ldVal;
        inSum = 0;
        for (int k = 0; k < P_N; k++) inSum += int'(i_trace[k*TW +: TW]);
        ld    = i_th_load;
        ldVal = int'(i_th_value);
        rstOk = i_rst_n;
        @(posedge i_clk);
        if (!rstOk) begin
            modelReset();
        end else begin
            fire = (mBusy == 0) && (mSum >= mTh);
            if (ld) begin
                mTh = (ldVal < P_TH_MIN) ? P_TH_MIN : ldVal;
                mDecay = 0;
            end else if (fire) begin
                mTh = (mTh + P_TH_INC > TH_MAX) ? TH_MAX : mTh + P_TH_INC;
                mDecay = 0;
            end else if (mBusy == 0) begin
                mDecay++;
                if (mDecay == P_TH_DECAY) begin
                    mDecay = 0;
                    mTh = (mTh - 1 < P_TH_MIN) ? P_TH_MIN : mTh - 1;
                end
            end
            if (fire) mBusy = 1 + P_REFRACT;
            else if (mBusy > 0) mBusy--;
            mSpike   = fire;
            mRefract = (mBusy > 0);
            mSum     = inSum;
        end
        #1;
        checkAll(tag);
    endtask

    task automatic runIdle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag);
    endtask

    initial begin
        i_rst_n = 1'b0; i_trace = '0; i_th_load = 1'b0; i_th_value = '0;
        modelReset();
        #12;
        checkAll("reset");
        i_rst_n = 1'b1;

        // Idle decay from the reset threshold
        runIdle("idle", 200);
        checkOutput("decay200", 32'(o_thresh), 32'd32765);

        // Threshold crossing and refractory spacing
        i_th_load = 1'b1; i_th_value = 18'd32768;
        applyStimulus("reload");
        i_th_load = 1'b0;
        setTraces(25600, 25600, 0, 0);
        applyStimulus("cross.sum");
        applyStimulus("cross.fire");
        checkOutput("cross.spike", 32'(o_spike), 32'd1);
        checkOutput("cross.thinc", 32'(o_thresh), 32'd34816);
        runIdle("cross.refr", 12);

        // Equality fires, one below does not
        setTraces(0, 0, 0, 0);
        runIdle("eq.quiet", 8);
        i_th_load = 1'b1; i_th_value = 18'd40000;
        setTraces(10000, 10000, 10000, 10000);
        applyStimulus("eq.load");
        i_th_load = 1'b0;
        applyStimulus("eq.fire");
        checkOutput("eq.spike", 32'(o_spike), 32'd1);
        setTraces(0, 0, 0, 0);
        runIdle("eq.quiet2", 8);
        i_th_load = 1'b1; i_th_value = 18'd40000;
        setTraces(10000, 10000, 10000, 9999);
        applyStimulus("below.load");
        i_th_load = 1'b0;
        runIdle("below", 10);

        // Ceiling saturation, then floor clamp on load and during long idle
        setTraces(0, 0, 0, 0);
        runIdle("sat.quiet", 8);
        i_th_load = 1'b1; i_th_value = 18'd262000;
        setTraces(65535, 65535, 65535, 65535);
        applyStimulus("sat.load");
        i_th_load = 1'b0;
        applyStimulus("sat.fire");
        checkOutput("sat.ceiling", 32'(o_thresh), 32'(TH_MAX));
        setTraces(0, 0, 0, 0);
        runIdle("sat.quiet2", 8);
        i_th_load = 1'b1; i_th_value = 18'd0;
        applyStimulus("floor.load");
        i_th_load = 1'b0;
        checkOutput("floor.clamp", 32'(o_thresh), 32'(P_TH_MIN));
        runIdle("floor.idle", 1000);
        checkOutput("floor.hold", 32'(o_thresh), 32'(P_TH_MIN));

        // Load wins over the spike increment on the firing edge
        setTraces(25600, 25600, 0, 0);
        applyStimulus("prio.sum");
        i_th_load = 1'b1; i_th_value = 18'd5000;
        applyStimulus("prio.fire");
        i_th_load = 1'b0;
        checkOutput("prio.thresh", 32'(o_thresh), 32'd5000);
        checkOutput("prio.spike", 32'(o_spike), 32'd1);

        // Reset while refractory
        runIdle("mid.refr", 2);
        i_rst_n = 1'b0;
        #2;
        modelReset();
        checkAll("mid.rst");
        runIdle("mid.held", 3);
        i_rst_n = 1'b1;
        applyStimulus("mid.rel1");
        checkOutput("mid.nospike", 32'(o_spike), 32'd0);
        applyStimulus("mid.rel2");
        checkOutput("mid.spike", 32'(o_spike), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            setTraces($urandom_range(0, 20000), $urandom_range(0, 20000),
                      $urandom_range(0, 20000), $urandom_range(0, 20000));
            i_th_load  = ($urandom_range(0, 49) == 0);
            i_th_value = 18'($urandom_range(0, 90000));
            applyStimulus("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
